vga_sprite_loader: RTL and testbench

//  Upstream fill stage for the 200x200 sprite buffer that the VGA display top reads each frame.
//  - Accepts an 8-bit byte stream (R,G,B order, MSB first) and packs every 3 bytes into one 24-bit pixel.
//  - Writes pixels to the buffer's write port at sequential addresses 0..PIX_COUNT-1.
//  - Writes occur only while wr_allow is high (blanking window supplied by the display side).
//  - Flags frame completion and start-of-frame resynchronisation.

---
 rtl/vga_sprite_loader.sv | 137 +++++++++++++
 tb/tb_vga_sprite_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_loader.sv
// Packs an R,G,B byte stream into 24-bit pixels and writes them to the sprite buffer
// at sequential addresses, gated by the display-side wr_allow window.
module vga_sprite_loader #(
    parameter int unsigned PIX_COUNT = 40000,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_sof,
    output logic              s_ready,
    input  logic              wr_allow,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              load_busy,
    output logic              frame_done,
    output logic              resync_err
);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(PIX_COUNT - 1);

    typedef enum logic {StIdle, StLoad} state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        red_q, red_d;
    logic [7:0]        grn_q, grn_d;
    logic [23:0]       pixel_q, pixel_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_d, frame_done_d, resync_err_d, load_busy_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [23:0]       wr_data_d;
    logic              accept;

    // While a pixel waits for wr_allow, the stream is stalled so nothing is lost.
    assign s_ready = !rst && (state_q == StIdle || !pend_q);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        red_d        = red_q;
        grn_d        = grn_q;
        pixel_d      = pixel_q;
        pend_d       = pend_q;
        addr_d       = addr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr;
        wr_data_d    = wr_data;
        frame_done_d = 1'b0;
        resync_err_d = 1'b0;
        load_busy_d  = (state_q == StLoad);

        unique case (state_q)
            StIdle: begin
                if (accept && s_sof) begin
                    red_d      = s_data;
                    byte_idx_d = 2'd1;
                    addr_d     = '0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (accept && s_sof) begin
                    // Start-of-frame mid-image: drop the partial pixel and restart at 0.
                    resync_err_d = 1'b1;
                    red_d        = s_data;
                    byte_idx_d   = 2'd1;
                    addr_d       = '0;
                end else if (accept) begin
                    case (byte_idx_q)
                        2'd0: begin
                            red_d      = s_data;
                            byte_idx_d = 2'd1;
                        end
                        2'd1: begin
                            grn_d      = s_data;
                            byte_idx_d = 2'd2;
                        end
                        default: begin
                            pixel_d    = {red_q, grn_q, s_data};
                            pend_d     = 1'b1;
                            byte_idx_d = 2'd0;
                        end
                    endcase
                end else if (pend_q && wr_allow) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = pixel_q;
                    pend_d    = 1'b0;
                    if (addr_q == LastAddr) begin
                        frame_done_d = 1'b1;
                        addr_d       = '0;
                        state_d      = StIdle;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            byte_idx_q <= 2'd0;
            red_q      <= '0;
            grn_q      <= '0;
            pixel_q    <= '0;
            pend_q     <= 1'b0;
            addr_q     <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            resync_err <= 1'b0;
            load_busy  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            red_q      <= red_d;
            grn_q      <= grn_d;
            pixel_q    <= pixel_d;
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            frame_done <= frame_done_d;
            resync_err <= resync_err_d;
            load_busy  <= load_busy_d;
        end
    end
endmodule

// File: tb/tb_vga_sprite_loader.sv
// Scoreboard bench: a byte-level image model predicts buffer writes and resync pulses;
// a negedge monitor pops and compares whenever the loader writes.
module tb_vga_sprite_loader;
    localparam int unsigned PC = 4;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_sof = 1'b0;
    logic          s_ready;
    logic          wr_allow;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          load_busy;
    logic          frame_done;
    logic          resync_err;

    logic rand_mode = 1'b0;
    logic allow_dir = 1'b1;
    logic allow_rnd = 1'b1;
    assign wr_allow = rand_mode ? allow_rnd : allow_dir;

    vga_sprite_loader #(.PIX_COUNT(PC), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .s_ready    (s_ready),
        .wr_allow   (wr_allow),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .load_busy  (load_busy),
        .frame_done (frame_done),
        .resync_err (resync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [23:0]   data;
        logic          fd;
    } wr_exp_t;

    wr_exp_t    exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         resync_exp = 0;
    int         resync_seen = 0;

    // Image model: tracks only whether an image is open, its pixel count and pending bytes.
    bit         m_active = 0;
    int         m_pix = 0;
    logic [7:0] m_bytes[$];

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_byte(input logic [7:0] d, input logic sof);
        wr_exp_t e;
        if (sof) begin
            if (m_active) resync_exp++;
            m_active = 1;
            m_pix = 0;
            m_bytes.delete();
            m_bytes.push_back(d);
        end else if (m_active) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == 3) begin
                e.addr = AW'(m_pix);
                e.data = {m_bytes[0], m_bytes[1], m_bytes[2]};
                e.fd   = (m_pix == PC - 1);
                exp_q.push_back(e);
                m_bytes.delete();
                m_pix++;
                if (m_pix == PC) m_active = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_pix = 0;
        m_bytes.delete();
        exp_q.delete();
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send(input logic [7:0] d, input logic sof);
        int waited = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        while (!s_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            check(0, "send_timeout", 32'(waited), 32'd2000);
        end else begin
            @(posedge clk);
            model_byte(d, sof);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    // Monitor
    always @(negedge clk) begin
        wr_exp_t e;
        if (!rst) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check(wr_addr == e.addr, "wr_addr", 32'(wr_addr), 32'(e.addr));
                    check(wr_data == e.data, "wr_data", 32'(wr_data), 32'(e.data));
                    check(frame_done == e.fd, "frame_done", 32'(frame_done), 32'(e.fd));
                end
            end else if (frame_done) begin
                check(0, "frame_done_no_write", 32'(frame_done), 32'd0);
            end
            if (resync_err) begin
                check(resync_seen < resync_exp, "resync_unexpected", 32'(resync_seen + 1),
                      32'(resync_exp));
                resync_seen++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            allow_rnd = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;

        // 1: reset holds everything quiet even with s_valid high
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        check(s_ready == 0, "rst_s_ready", 32'(s_ready), 32'd0);
        check(wr_en == 0, "rst_wr_en", 32'(wr_en), 32'd0);
        check(load_busy == 0, "rst_load_busy", 32'(load_busy), 32'd0);
        s_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check(s_ready == 1, "post_rst_s_ready", 32'(s_ready), 32'd1);
        check(load_busy == 0, "post_rst_idle", 32'(load_busy), 32'd0);

        // 2: non-sof bytes in IDLE are dropped, then a pixel with latency checks
        allow_dir = 1'b1;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        repeat (3) @(negedge clk);
        send(8'hAA, 1'b1);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        check(wr_en == 0, "lat_no_wr_yet", 32'(wr_en), 32'd0);
        check(s_ready == 0, "lat_ready_low", 32'(s_ready), 32'd0);
        @(negedge clk);
        check(wr_en == 1, "lat_wr_en", 32'(wr_en), 32'd1);
        check(s_ready == 1, "lat_ready_back", 32'(s_ready), 32'd1);

        // 3: full image of PC pixels; frame_done on last write, load_busy falls after
        for (int i = 1; i <= 12; i++) send(8'(i), i == 1);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (frame_done) got = 1;
            else @(negedge clk);
        end
        check(got, "frame_done_seen", 32'(got), 32'd1);
        if (got) begin
            check(load_busy == 1, "busy_at_done", 32'(load_busy), 32'd1);
            @(negedge clk);
            check(load_busy == 0, "busy_falls", 32'(load_busy), 32'd0);
        end

        // 4: stalled pixel is held while wr_allow is low
        allow_dir = 1'b0;
        send(8'hC1, 1'b1);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        for (int i = 0; i < 100; i++) begin
            check(s_ready == 0, "stall_ready", 32'(s_ready), 32'd0);
            check(wr_en == 0, "stall_no_wr", 32'(wr_en), 32'd0);
            @(negedge clk);
        end
        allow_dir = 1'b1;
        @(negedge clk);
        check(wr_en == 1, "stall_release_wr", 32'(wr_en), 32'd1);
        check(s_ready == 1, "stall_release_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b0;
        @(negedge clk);

        // 5: resync mid-image
        send(8'hA0, 1'b1);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        repeat (3) @(negedge clk);
        send(8'h55, 1'b1);
        check(resync_err == 1, "resync_pulse", 32'(resync_err), 32'd1);
        @(negedge clk);
        check(resync_err == 0, "resync_one_cycle", 32'(resync_err), 32'd0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        repeat (3) @(negedge clk);

        // 6: async reset after 2 pixels of the current image are written
        send(8'h81, 1'b0);
        send(8'h82, 1'b0);
        send(8'h83, 1'b0);
        send(8'h84, 1'b0);
        repeat (3) @(negedge clk);
        check(load_busy == 1, "pre_rst_busy", 32'(load_busy), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check(wr_en == 0, "arst_wr_en", 32'(wr_en), 32'd0);
        check(wr_addr == 0, "arst_wr_addr", 32'(wr_addr), 32'd0);
        check(wr_data == 0, "arst_wr_data", 32'(wr_data), 32'd0);
        check(load_busy == 0, "arst_busy", 32'(load_busy), 32'd0);
        check(s_ready == 0, "arst_ready", 32'(s_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) send(8'($urandom), i == 0);
        repeat (4) @(negedge clk);

        // Randomized stream: random bytes, gaps, stray sofs and a random write window
        rand_mode = 1'b1;
        for (int k = 0; k < 400; k++) begin
            send(8'($urandom), (k == 0) || ($urandom_range(0, 24) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Drain and final scoreboard checks
        rand_mode = 1'b0;
        allow_dir = 1'b1;
        repeat (20) @(negedge clk);
        check(exp_q.size() == 0, "writes_outstanding", 32'(exp_q.size()), 32'd0);
        check(resync_seen == resync_exp, "resync_count", 32'(resync_seen), 32'(resync_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
